// File: rtl/adc_core_model.sv
// Digital stand-in for the 12-bit SAR ADC macro: power-up/cal sequencing plus free-running
// 13-cycle SAR conversions. Optional cal offset trim under `ADC_CAL_OFFSET_EN`.
module adc_core_model #(
  parameter int PWRUP_CYCLES = 8,
  parameter int CAL_CYCLES   = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [2:0]  ADC_CTRL,
  input  logic [11:0] AIN,
  output logic        ADC_PWON,
  output logic        ADC_RDY,
  output logic [11:0] ADC_B
);

  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_PWRUP = 2'd1;
  localparam logic [1:0] S_CAL   = 2'd2;
  localparam logic [1:0] S_READY = 2'd3;

  localparam logic [7:0] PWRUP_LAST = 8'(PWRUP_CYCLES - 1);
  localparam logic [7:0] CAL_LAST   = 8'(CAL_CYCLES - 1);
  localparam logic [3:0] STEP_LAST  = 4'd12;

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [3:0]  step;
  logic [11:0] smp;
  logic [11:0] trial;
  logic [11:0] trial_nxt;
  logic [11:0] smp_eff;
  logic [11:0] probe;
  logic [3:0]  bit_idx;
  logic        cal_q;
  logic        on;
  logic        cal_rise;
  logic        cal_done;

  assign on       = (ADC_CTRL[2:1] != 2'b00);
  assign cal_rise = ADC_CTRL[0] & ~cal_q;
  assign cal_done = (state == S_CAL) && (cnt == CAL_LAST);

`ifdef ADC_CAL_OFFSET_EN
  // Offset is trimmed from AIN on the last cal cycle and kept across power-down.
  logic [11:0] offset;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)
      offset <= '0;
    else if (on && cal_done)
      offset <= AIN;
  end

  assign smp_eff = (smp > offset) ? (smp - offset) : 12'd0;
`else
  assign smp_eff = smp;
`endif

  // One SAR decision per step, MSB first: keep the trial bit if the probe does not overshoot.
  always_comb begin
    trial_nxt = trial;
    bit_idx   = STEP_LAST - step;
    probe     = trial | (12'd1 << bit_idx);
    if (step != 4'd0)
      trial_nxt[bit_idx] = (probe <= smp_eff);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= S_OFF;
      cnt      <= '0;
      step     <= '0;
      smp      <= '0;
      trial    <= '0;
      cal_q    <= 1'b0;
      ADC_PWON <= 1'b0;
      ADC_RDY  <= 1'b0;
      ADC_B    <= '0;
    end else begin
      cal_q <= ADC_CTRL[0];
      if (!on) begin
        state    <= S_OFF;
        ADC_PWON <= 1'b0;
        ADC_RDY  <= 1'b0;
      end else begin
        case (state)
          S_OFF: begin
            state <= S_PWRUP;
            cnt   <= '0;
          end
          S_PWRUP: begin
            if (cnt == PWRUP_LAST) begin
              state    <= S_CAL;
              ADC_PWON <= 1'b1;
              cnt      <= '0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          S_CAL: begin
            if (cal_done) begin
              state   <= S_READY;
              ADC_RDY <= 1'b1;
              step    <= '0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          S_READY: begin
            // A fresh cal request aborts the conversion in flight; ADC_B keeps its last value.
            if (cal_rise) begin
              state   <= S_CAL;
              ADC_RDY <= 1'b0;
              cnt     <= '0;
            end else if (step == 4'd0) begin
              smp   <= AIN;
              trial <= '0;
              step  <= 4'd1;
            end else begin
              trial <= trial_nxt;
              if (step == STEP_LAST) begin
                ADC_B <= trial_nxt;
                step  <= '0;
              end else begin
                step <= step + 4'd1;
              end
            end
          end
          default: state <= S_OFF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_core_model.sv
// Bench for adc_core_model: directed vector table, hand sequences for reset/offset,
// then randomized traffic against a timeline-based reference model.
module tb_adc_core_model;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic [2:0]  ADC_CTRL = 3'b000;
  logic [11:0] AIN = 12'h000;
  logic        ADC_PWON;
  logic        ADC_RDY;
  logic [11:0] ADC_B;

  always #5 PCLK = ~PCLK;

  adc_core_model dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .ADC_CTRL (ADC_CTRL),
    .AIN      (AIN),
    .ADC_PWON (ADC_PWON),
    .ADC_RDY  (ADC_RDY),
    .ADC_B    (ADC_B)
  );

  typedef struct {
    logic [2:0]  ctrl;
    logic [11:0] ain;
    int          n;
    logic        pwon;
    logic        rdy;
    logic [11:0] b;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nmis = 0;

  task automatic check(input string name, input logic pw, input logic rd, input logic [11:0] b);
    nvec++;
    if (ADC_PWON !== pw || ADC_RDY !== rd || ADC_B !== b) begin
      nmis++;
      $display("FAIL %s: got pwon=%0b rdy=%0b b=%h, want pwon=%0b rdy=%0b b=%h",
               name, ADC_PWON, ADC_RDY, ADC_B, pw, rd, b);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  function automatic void row(input logic [2:0] c, input logic [11:0] a, input int n,
                              input logic p, input logic r, input logic [11:0] b);
    tbl.push_back('{ctrl: c, ain: a, n: n, pwon: p, rdy: r, b: b});
  endfunction

  // Reference model state: absolute edge numbers at which events are due.
  int          e;
  bit          m_powered, m_pwon, m_rdy, prev_cal;
  int          m_pwon_at, m_rdy_at;
  logic [11:0] m_smp, m_b, m_off;

  function automatic logic [11:0] eff(input logic [11:0] s, input logic [11:0] off);
`ifdef ADC_CAL_OFFSET_EN
    return (s > off) ? s - off : 12'h000;
`else
    return s;
`endif
  endfunction

  task automatic model_edge();
    bit on, rise;
    int k;
    e++;
    on   = (ADC_CTRL[2:1] != 2'b00);
    rise = ADC_CTRL[0] && !prev_cal;
    if (!on) begin
      m_powered = 0; m_pwon = 0; m_rdy = 0;
    end else if (!m_powered) begin
      m_powered = 1;
      m_pwon_at = e + 8;
      m_rdy_at  = e + 24;
    end else begin
      if (m_rdy && rise) begin
        m_rdy    = 0;
        m_rdy_at = e + 16;
      end else if (!m_rdy && e == m_rdy_at) begin
        m_rdy = 1;
`ifdef ADC_CAL_OFFSET_EN
        m_off = AIN;
`endif
      end else if (m_rdy) begin
        k = (e - m_rdy_at) % 13;
        if (k == 1) m_smp = AIN;
        if (k == 0) m_b = eff(m_smp, m_off);
      end
      if (e == m_pwon_at) m_pwon = 1;
    end
  endtask

  initial begin
    int off_left;
    logic [1:0] opm;
    logic cal;

    // Reset state
    tick(2);
    check("reset", 1'b0, 1'b0, 12'h000);
    PRESETn = 1'b1;

    // Power-up, cal, conversion with mid-flight AIN change
    row(3'b110, 12'h000, 8,  0, 0, 12'h000);
    row(3'b110, 12'h000, 1,  1, 0, 12'h000);
    row(3'b110, 12'h000, 15, 1, 0, 12'h000);
    row(3'b110, 12'h000, 1,  1, 1, 12'h000);
    row(3'b110, 12'hA5C, 12, 1, 1, 12'h000);
    row(3'b110, 12'hA5C, 1,  1, 1, 12'hA5C);
    row(3'b110, 12'hA5C, 5,  1, 1, 12'hA5C);
    row(3'b110, 12'h001, 7,  1, 1, 12'hA5C);
    row(3'b110, 12'h001, 1,  1, 1, 12'hA5C);
    row(3'b110, 12'h001, 13, 1, 1, 12'h001);
    // Cal rising edge, held high: one recal only, ADC_B held through CAL
    row(3'b111, 12'h000, 1,  1, 0, 12'h001);
    row(3'b111, 12'h000, 15, 1, 0, 12'h001);
    row(3'b111, 12'h000, 1,  1, 1, 12'h001);
    row(3'b111, 12'h3C7, 12, 1, 1, 12'h001);
    row(3'b111, 12'h3C7, 1,  1, 1, 12'h3C7);
    row(3'b111, 12'h3C7, 13, 1, 1, 12'h3C7);
    row(3'b111, 12'h3C7, 7,  1, 1, 12'h3C7);
    // Power down at step 7, then full re-power sequence
    row(3'b000, 12'h3C7, 1,  0, 0, 12'h3C7);
    row(3'b000, 12'h3C7, 5,  0, 0, 12'h3C7);
    row(3'b110, 12'h000, 8,  0, 0, 12'h3C7);
    row(3'b110, 12'h000, 1,  1, 0, 12'h3C7);
    row(3'b110, 12'h000, 15, 1, 0, 12'h3C7);
    row(3'b110, 12'h000, 1,  1, 1, 12'h3C7);

    foreach (tbl[i]) begin
      ADC_CTRL = tbl[i].ctrl;
      AIN      = tbl[i].ain;
      tick(tbl[i].n);
      check($sformatf("tbl[%0d]", i), tbl[i].pwon, tbl[i].rdy, tbl[i].b);
    end

    // Async reset in the middle of CAL
    ADC_CTRL = 3'b111;
    tick(1);
    check("t5_cal_entry", 1'b1, 1'b0, 12'h3C7);
    tick(4);
    #3 PRESETn = 1'b0;
    #1 check("t5_async_rst", 1'b0, 1'b0, 12'h000);
    tick(1);
    ADC_CTRL = 3'b110;
    PRESETn  = 1'b1;
    tick(8);
    check("t5_off_pwrup", 1'b0, 1'b0, 12'h000);
    tick(1);
    check("t5_pwon", 1'b1, 1'b0, 12'h000);

`ifdef ADC_CAL_OFFSET_EN
    PRESETn  = 1'b0;
    ADC_CTRL = 3'b110;
    AIN      = 12'h010;
    tick(1);
    PRESETn = 1'b1;
    tick(25);
    check("t6_rdy", 1'b1, 1'b1, 12'h000);
    AIN = 12'h100;
    tick(13);
    check("t6_sub", 1'b1, 1'b1, 12'h0F0);
    AIN = 12'h008;
    tick(13);
    check("t6_sat", 1'b1, 1'b1, 12'h000);
`endif

    // Randomized traffic against the reference model
    PRESETn  = 1'b0;
    ADC_CTRL = 3'b000;
    tick(1);
    PRESETn   = 1'b1;
    e         = 0;
    m_powered = 0; m_pwon = 0; m_rdy = 0; prev_cal = 0;
    m_pwon_at = -1; m_rdy_at = -1;
    m_smp = '0; m_b = '0; m_off = '0;
    off_left = 0;
    cal      = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (off_left > 0) begin
        opm = 2'b00;
        off_left--;
      end else if ($urandom_range(0, 299) == 0) begin
        opm = 2'b00;
        off_left = $urandom_range(0, 5);
      end else if ($urandom_range(0, 9) == 0) begin
        opm = 2'($urandom_range(1, 2));
      end else begin
        opm = 2'b11;
      end
      if ($urandom_range(0, 39) == 0) cal = ~cal;
      ADC_CTRL = {opm, cal};
      AIN      = 12'($urandom);
      model_edge();
      tick(1);
      check("rand", m_pwon, m_rdy, m_b);
      prev_cal = ADC_CTRL[0];
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
